// File: rtl/data_memory_responder_pkg.sv
// ---------------------------------------------------------------------------
// data_memory_responder_pkg
//   Shared definitions for the data-memory responder slice: word and address
//   widths, the responder state encoding and a small address-check helper.
// ---------------------------------------------------------------------------
package data_memory_responder_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // A word access must start on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
    return (addr_lsbs != 2'b00);
  endfunction

endpackage

// File: rtl/data_memory_responder_word_ram.sv
// ---------------------------------------------------------------------------
// word_ram
//   Single-port word storage: synchronous write, asynchronous read.
//   No reset; contents are undefined until written.
// Ports:
//   clk    in   write clock, rising edge
//   we     in   write enable
//   index  in   word index for both read and write
//   wdata  in   write data
//   rdata  out  word currently stored at index
// ---------------------------------------------------------------------------
module word_ram
  import data_memory_responder_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] index,
  input  logic [WORD_WIDTH-1:0]    wdata,
  output logic [WORD_WIDTH-1:0]    rdata
);

  logic [WORD_WIDTH-1:0] r_mem [DEPTH];

  // Word write on the rising edge.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[index] <= wdata;
    end
  end

  assign rdata = r_mem[index];

endmodule

// File: rtl/data_memory_responder.sv
// ---------------------------------------------------------------------------
// data_memory_responder
//   Responder end of the CPU load/store port. Accepts one word request at a
//   time, waits LATENCY edges, performs the access and holds the response
//   until the requester consumes it.
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   req_valid   in   request present
//   req_ready   out  responder can accept a request (IDLE only)
//   req_we      in   1 = store, 0 = load
//   req_addr    in   byte address
//   req_wdata   in   store data
//   resp_valid  out  response present
//   resp_ready  in   requester consumes the response
//   resp_rdata  out  load data; 0 for stores and errors
//   resp_err    out  misaligned or out-of-range access
// ---------------------------------------------------------------------------
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WORD_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WORD_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  // Byte-address limit held one bit wider so DEPTH*4 cannot wrap.
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT =
    (ADDR_WIDTH+1)'(DEPTH) * (ADDR_WIDTH+1)'(4);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_cnt;
  logic                  r_we;
  logic                  r_err;
  logic [IDX_W-1:0]      r_idx;
  logic [WORD_WIDTH-1:0] r_wdata;
  logic [WORD_WIDTH-1:0] r_rdata;
  logic                  r_resp_err;

  logic                  w_addr_err;
  logic                  w_accept;
  logic                  w_access;
  logic                  w_ram_we;
  logic [WORD_WIDTH-1:0] w_ram_rdata;

  assign w_addr_err = is_misaligned(req_addr[1:0]) |
                      ({1'b0, req_addr} >= ADDR_LIMIT);
  assign w_accept   = (r_state == IDLE) && req_valid;
  // The access happens on the last WAIT edge; errored stores never write.
  assign w_access   = (r_state == WAIT) && (r_cnt == 4'd0);
  assign w_ram_we   = w_access && r_we && !r_err;

  word_ram #(
    .DEPTH(DEPTH)
  ) u_word_ram (
    .clk  (clk),
    .we   (w_ram_we),
    .index(r_idx),
    .wdata(r_wdata),
    .rdata(w_ram_rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_state_nxt = WAIT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = RESP;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      RESP: begin
        if (resp_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = RESP;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake outputs; req_ready is held low while reset is asserted.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready  = rst_n;
        resp_valid = 1'b0;
      end
      WAIT: begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
      end
      RESP: begin
        req_ready  = 1'b0;
        resp_valid = 1'b1;
      end
      default: begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
      end
    endcase
  end

  // Request capture, latency counter and response data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= 4'd0;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_resp_err <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= CNT_INIT;
      r_we    <= req_we;
      r_err   <= w_addr_err;
      r_idx   <= req_addr[IDX_W+1:2];
      r_wdata <= req_wdata;
    end else if (r_state == WAIT) begin
      if (r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end else begin
        r_rdata    <= (r_we || r_err) ? '0 : w_ram_rdata;
        r_resp_err <= r_err;
      end
    end else if ((r_state == RESP) && resp_ready) begin
      r_rdata    <= '0;
      r_resp_err <= 1'b0;
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_data_memory_responder.sv
// ---------------------------------------------------------------------------
// tb_data_memory_responder
//   Directed and randomized requests against an associative-array model of
//   the word storage. Inputs are driven at the falling edge or just after the
//   rising edge; outputs are sampled at the falling edge.
// ---------------------------------------------------------------------------
module tb_data_memory_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b0;
  logic        req_valid  = 1'b0;
  logic        req_ready;
  logic        req_we     = 1'b0;
  logic [31:0] req_addr   = 32'h0;
  logic [31:0] req_wdata  = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference storage: word index -> last committed store data.
  logic [31:0] mem_m [int];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  data_memory_responder #(
    .DEPTH  (DEPTH),
    .LATENCY(LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic exp_error(input logic [31:0] addr);
    return (addr % 4 != 0) || (addr >= 32'(DEPTH * 4));
  endfunction

  // One complete transaction; leaves the bench at a falling edge in IDLE.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input int stall, input logic hold_valid,
                     output int acc_cyc, output logic [31:0] rd);
    logic        e_err;
    logic [31:0] e_rd;
    logic        known;
    int          idx;
    int          w;
    int          lat;
    e_err = exp_error(addr);
    idx   = int'(addr / 4);
    known = 1'b1;
    if (e_err || we) e_rd = 32'h0;
    else if (mem_m.exists(idx)) e_rd = mem_m[idx];
    else begin
      e_rd  = 32'h0;
      known = 1'b0;
    end

    req_we = we; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) check_val("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (!hold_valid) req_valid = 1'b0;

    @(negedge clk);
    lat = 0;
    while (!resp_valid && lat < 40) begin
      check_val("ready_in_wait", {31'h0, req_ready}, 32'h0);
      @(negedge clk);
      lat++;
    end
    check_val("latency", 32'(lat), 32'(LAT));
    check_val("resp_err", {31'h0, resp_err}, {31'h0, e_err});
    if (known) check_val("resp_rdata", resp_rdata, e_rd);
    rd = resp_rdata;
    if (we && !e_err) mem_m[idx] = wdata;

    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check_val("bp_valid", {31'h0, resp_valid}, 32'h1);
      check_val("bp_rdata", resp_rdata, known ? e_rd : rd);
      check_val("bp_err", {31'h0, resp_err}, {31'h0, e_err});
      check_val("bp_ready", {31'h0, req_ready}, 32'h0);
    end

    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    check_val("done_valid", {31'h0, resp_valid}, 32'h0);
    check_val("done_ready", {31'h0, req_ready}, 32'h1);
    check_val("done_rdata", resp_rdata, 32'h0);
  endtask

  // Accepts a store and leaves the bench at a falling edge in WAIT or RESP.
  task automatic start_store(input logic [31:0] addr, input logic [31:0] wdata, input logic to_resp);
    int w;
    req_we = 1'b1; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    if (to_resp) begin
      w = 0;
      while (!resp_valid && w < 40) begin
        @(negedge clk);
        w++;
      end
      check_val("commit_valid", {31'h0, resp_valid}, 32'h1);
    end else begin
      check_val("wait_valid", {31'h0, resp_valid}, 32'h0);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check_val("rst_ready", {31'h0, req_ready}, 32'h0);
    check_val("rst_valid", {31'h0, resp_valid}, 32'h0);
    check_val("rst_rdata", resp_rdata, 32'h0);
    check_val("rst_err", {31'h0, resp_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("rel_ready", {31'h0, req_ready}, 32'h1);
    @(negedge clk);
  endtask

  initial begin
    int          acc [4];
    int          a;
    logic [31:0] rd;
    logic [31:0] addr;
    int          pick;

    // Reset state.
    repeat (2) @(negedge clk);
    check_val("reset_ready", {31'h0, req_ready}, 32'h0);
    check_val("reset_valid", {31'h0, resp_valid}, 32'h0);
    check_val("reset_rdata", resp_rdata, 32'h0);
    check_val("reset_err", {31'h0, resp_err}, 32'h0);
    rst_n = 1'b1;
    #1;
    check_val("release_ready", {31'h0, req_ready}, 32'h1);
    @(negedge clk);

    // Store then load.
    txn(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, a, rd);
    txn(1'b0, 32'h10, 32'h0, 0, 1'b0, a, rd);
    check_val("load_0x10", rd, 32'hDEADBEEF);

    // Misaligned store is rejected and leaves storage alone.
    txn(1'b1, 32'h12, 32'h12345678, 0, 1'b0, a, rd);
    txn(1'b0, 32'h10, 32'h0, 0, 1'b0, a, rd);
    check_val("load_after_misaligned", rd, 32'hDEADBEEF);

    // Range boundaries.
    txn(1'b0, 32'h1000, 32'h0, 0, 1'b0, a, rd);
    txn(1'b1, 32'hFFC, 32'hA5A55A5A, 0, 1'b0, a, rd);
    txn(1'b0, 32'hFFC, 32'h0, 0, 1'b0, a, rd);
    check_val("load_top_word", rd, 32'hA5A55A5A);
    txn(1'b0, 32'hFFFF_FFFC, 32'h0, 0, 1'b0, a, rd);

    // Backpressure.
    txn(1'b0, 32'h10, 32'h0, 5, 1'b0, a, rd);

    // Streaming with req_valid held high.
    for (int i = 0; i < 4; i++) begin
      txn(1'b0, 32'h10, 32'h0, 0, 1'b1, acc[i], rd);
    end
    req_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      check_val("stream_gap", 32'(acc[i] - acc[i-1]), 32'(LAT + 2));
    end

    // Reset during WAIT discards the store.
    txn(1'b1, 32'h20, 32'h11112222, 0, 1'b0, a, rd);
    start_store(32'h20, 32'hCAFEF00D, 1'b0);
    pulse_reset();
    txn(1'b0, 32'h20, 32'h0, 0, 1'b0, a, rd);
    check_val("load_after_wait_reset", rd, 32'h11112222);

    // Reset during RESP keeps the committed store.
    start_store(32'h24, 32'h0BADCAFE, 1'b1);
    mem_m[9] = 32'h0BADCAFE;
    pulse_reset();
    txn(1'b0, 32'h24, 32'h0, 0, 1'b0, a, rd);
    check_val("load_after_resp_reset", rd, 32'h0BADCAFE);

    // Randomized mix of loads, stores and error cases.
    for (int i = 0; i < 60; i++) begin
      pick = int'($urandom_range(0, 9));
      if (pick <= 5)      addr = 32'($urandom_range(0, 15)) * 32'd4;
      else if (pick <= 7) addr = 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(1, 3));
      else if (pick == 8) addr = 32'(DEPTH * 4) + 32'($urandom_range(0, 255)) * 32'd4;
      else                addr = 32'(DEPTH * 4 - 4);
      txn(1'($urandom_range(0, 1)), addr, $urandom, int'($urandom_range(0, 3)), 1'b0, a, rd);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Responder end of the CPU data-memory load/store port: accepts one word-sized read or write request at a time over a valid/ready handshake, waits a configurable number of cycles, then returns a response.
- Sits between the CPU core's load/store path and the word storage array.
- Replaces the zero-latency combinational data memory, so the core can be exercised against realistic wait states.

Parameters:
- DEPTH, 1024, number of 32-bit words stored; power of two, at least 4.
- LATENCY, 2, clock edges from request acceptance to response valid; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store word, 0 = load word.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester consumes the response.
- resp_rdata  out  32  load data; 0 for stores and errors.
- resp_err  out  1  misaligned or out-of-range access.

Behaviour:
- Reset is asynchronous and active-low; clk is the single clock.
  - Outputs on reset: state IDLE, req_ready=0 while rst_n low and 1 after release, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0.
  - Reset does not clear storage; contents after power-up are undefined.
- Word index is req_addr[log2(DEPTH)+1:2].
- Error conditions:
  - Misaligned: req_addr[1:0] != 0.
  - Out of range: req_addr >= DEPTH*4.
  - Either condition gives resp_err=1 and resp_rdata=0, and storage is never written.
- States:
  - IDLE: req_ready=1. When req_valid is high at a rising edge, latch we, addr, wdata and the error flag, load cnt=LATENCY-1, and go to WAIT.
  - WAIT: req_ready=0. Decrement cnt each edge. On the edge where cnt==0, perform the access and go to RESP.
    - Load: resp_rdata is the stored word.
    - Store without error: the word is written on that edge.
  - RESP: resp_valid=1; resp_rdata and resp_err are held stable. On an edge with resp_ready=1, clear resp_valid, resp_rdata and resp_err and go to IDLE.
- Only one transaction is outstanding. req_ready is combinationally 1 only in IDLE and does not depend on req_valid.
- Latency: a request accepted at edge N gives resp_valid=1 after edge N+LATENCY.
- Throughput: with resp_ready held at 1, one transaction completes every LATENCY+2 cycles.
- Back-to-back requests: a request presented during WAIT or RESP is not accepted; the requester must hold req_valid and its fields until it sees req_ready=1.
- Simultaneous events: in RESP with resp_ready=1 and req_valid=1, the response completes and the state returns to IDLE. The new request is accepted on the following edge, not the same one.
- Read-after-write: a load issued after a store's response returns the stored data.
- resp_ready held low: RESP persists indefinitely with outputs stable.
- Reset mid-operation:
  - A store still in WAIT is discarded; storage is unchanged.
  - A store already committed (state RESP) remains written.
  - Any pending response is dropped.
- Word write is atomic; there are no byte enables.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE, WAIT, RESP) as a 2-bit typedef;
  - the WORD_WIDTH=32 constant;
  - the ADDR_WIDTH=32 constant.
- One sub-module, word_ram: single-port synchronous-write, asynchronous-read array with DEPTH x 32 bits and ports clk, we, index, wdata, rdata. It has no reset.
- The FSM, counter and error check stay in data_memory_responder.

Test Plan:
- Store then load, LATENCY=2: store 0xDEADBEEF to 0x10, then load 0x10. resp_valid rises 2 edges after each acceptance; the load returns resp_rdata=0xDEADBEEF with resp_err=0.
- Misaligned store: store 0x12345678 to 0x12. Response has resp_err=1 and rdata=0. A subsequent load of 0x10 still returns 0xDEADBEEF.
- Out of range, DEPTH=1024: load 0x1000. Response has resp_err=1 and resp_rdata=0.
- Backpressure: hold resp_ready=0 for 5 cycles after a load of 0x10. resp_valid and rdata stay stable and req_ready=0 throughout. Raising resp_ready gives IDLE on the next edge and req_ready=1.
- Streaming: keep req_valid high with 4 successive loads and resp_ready=1. The requests are accepted every LATENCY+2 cycles and no request is accepted in WAIT or RESP.
- Reset mid-store: accept a store of 0xCAFEF00D to 0x20 and pulse rst_n low during WAIT. Outputs go to reset values immediately; a subsequent load of 0x20 returns the prior value, not 0xCAFEF00D.
